// File: rtl/sar_search_ctrl_pkg.sv
// Shared types for the SAR search controller: FSM state encoding and the
// comparator flag one-hot check.
package sar_search_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      FIN
   } state_t;

   // Exactly one of g/e/l must be set for the comparator answer to be legal.
   function automatic logic flags_onehot(input logic g, input logic e, input logic l);
      return ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001);
   endfunction

endpackage

// File: rtl/sar_search_ctrl_flag_check.sv
// Combinational check of the comparator answer for the current probe, and the
// narrowed search window that answer implies.
module search_flag_check
   import sar_search_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             g,
   input  logic             e,
   input  logic             l,
   input  logic [WIDTH-1:0] probe,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   output logic             flag_ok,
   output logic [WIDTH-1:0] next_lo,
   output logic [WIDTH-1:0] next_hi
);

   localparam logic [WIDTH-1:0] MAXV = '1;

   logic [WIDTH:0] lo_w;
   logic [WIDTH:0] hi_w;

   // Validate flags and narrow [lo,hi]; one extra bit keeps lo>hi detectable.
   always_comb begin
      lo_w    = {1'b0, lo};
      hi_w    = {1'b0, hi};
      flag_ok = flags_onehot(g, e, l);
      if (g) begin
         if (probe == '0) flag_ok = 1'b0;
         else             hi_w    = {1'b0, probe} - (WIDTH+1)'(1);
      end
      if (l) begin
         if (probe == MAXV) flag_ok = 1'b0;
         else               lo_w    = {1'b0, probe} + (WIDTH+1)'(1);
      end
      if (lo_w > hi_w) flag_ok = 1'b0;
      next_lo = lo_w[WIDTH-1:0];
      next_hi = hi_w[WIDTH-1:0];
   end

endmodule

// File: rtl/sar_search_ctrl.sv
// Binary-search controller: drives probe values into an external magnitude
// comparator and narrows [lo,hi] from its g/e/l answer until it hits equality.
module sar_search_ctrl
   import sar_search_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] probe,
   input  logic             cmp_g,
   input  logic             cmp_e,
   input  logic             cmp_l,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] found,
   output logic [CNT_W-1:0] probes
);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   span;
   logic [WIDTH-1:0] mid;
   logic             flag_ok;
   logic [WIDTH-1:0] next_lo;
   logic [WIDTH-1:0] next_hi;

   // lo <= hi holds whenever DRIVE is entered, so the midpoint never exceeds hi
   // and fits back into WIDTH bits.
   assign span = {1'b0, hi} - {1'b0, lo};
   assign mid  = lo + WIDTH'(span >> 1);

   search_flag_check #(
      .WIDTH(WIDTH)
   ) u_flag_check (
      .g      (cmp_g),
      .e      (cmp_e),
      .l      (cmp_l),
      .probe  (probe),
      .lo     (lo),
      .hi     (hi),
      .flag_ok(flag_ok),
      .next_lo(next_lo),
      .next_hi(next_hi)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state decode: one DRIVE/SAMPLE pair per probe, FIN holds the pulse.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = DRIVE;
         DRIVE:   state_n = SAMPLE;
         SAMPLE:  if (!flag_ok || cmp_e) state_n = FIN;
                  else                   state_n = DRIVE;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Search window, probe counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         probe  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         found  <= '0;
         probes <= '0;
         lo     <= '0;
         hi     <= '1;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lo   <= '0;
                  hi   <= '1;
                  cnt  <= '0;
                  busy <= 1'b1;
               end
            end
            DRIVE: begin
               probe <= mid;
               cnt   <= cnt + CNT_W'(1);
            end
            SAMPLE: begin
               if (!flag_ok) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
               end else if (cmp_e) begin
                  found  <= probe;
                  probes <= cnt;
                  done   <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  lo <= next_lo;
                  hi <= next_hi;
               end
            end
            FIN: begin
               done <= 1'b0;
               err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl with a behavioural comparator and a
// reference search model.
module tb_sar_search_ctrl;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] probe;
   logic             cmp_g, cmp_e, cmp_l;
   logic             busy, done, err;
   logic [WIDTH-1:0] found;
   logic [CNT_W-1:0] probes;

   int tgt  = 0;
   int mode = 0;   // 0: honest, 1: g&l when probe==7, 2: always g

   typedef struct packed {
      logic            is_err;
      logic [3:0]      found;
      logic [2:0]      probes;
      logic [3:0]      n;
      logic [7:0][3:0] seq;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         completions = 0;
   logic [3:0] last_found = '0;
   logic [2:0] last_probes = '0;

   always #5 clk = ~clk;

   sar_search_ctrl #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .probe (probe),
      .cmp_g (cmp_g),
      .cmp_e (cmp_e),
      .cmp_l (cmp_l),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .found (found),
      .probes(probes)
   );

   // Comparator answer for probe p against target t under the given mode.
   function automatic logic [2:0] resp(int m, int t, int p);
      logic [2:0] honest;
      honest = (p > t) ? 3'b100 : (p == t) ? 3'b010 : 3'b001;
      case (m)
         1:       return (p == 7) ? 3'b101 : honest;
         2:       return 3'b100;
         default: return honest;
      endcase
   endfunction

   assign {cmp_g, cmp_e, cmp_l} = resp(mode, tgt, int'(probe));

   // Reference search: halve the window by plain integer arithmetic.
   function automatic exp_t model(int t, int m);
      exp_t       x;
      int         lo, hi, p;
      logic [2:0] f;
      x = '0;
      lo = 0;
      hi = 15;
      for (int k = 0; k < 8; k++) begin
         p = lo + (hi - lo) / 2;
         x.seq[k] = 4'(p);
         x.n = 4'(k + 1);
         f = resp(m, t, p);
         if (f != 3'b100 && f != 3'b010 && f != 3'b001) begin x.is_err = 1'b1; break; end
         if (f == 3'b010) begin x.found = 4'(p); x.probes = 3'(k + 1); break; end
         if (f == 3'b100) begin
            if (p == 0) begin x.is_err = 1'b1; break; end
            hi = p - 1;
         end else begin
            if (p == 15) begin x.is_err = 1'b1; break; end
            lo = p + 1;
         end
         if (lo > hi) begin x.is_err = 1'b1; break; end
      end
      return x;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: collect probes seen in each SAMPLE, score each done/err pulse.
   int         bcnt = 0;
   logic [3:0] obs[$];
   always @(negedge clk) begin
      exp_t x;
      if (rst) begin
         bcnt = 0;
         obs.delete();
      end else begin
         if (busy) begin
            if (bcnt % 2 == 1) obs.push_back(probe);
            bcnt++;
         end
         if (done || err) begin
            check("done_err_exclusive", int'(done && err), 0);
            check("busy_low_at_end", int'(busy), 0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_completion: got done=%0d err=%0d, expected none", done, err);
            end else begin
               x = q.pop_front();
               check("err_flag", int'(err), int'(x.is_err));
               check("done_flag", int'(done), int'(!x.is_err));
               check("found", int'(found), int'(x.found));
               check("probes", int'(probes), int'(x.probes));
               check("probe_count", obs.size(), int'(x.n));
               check("latency", bcnt, 2 * int'(x.n));
               for (int i = 0; i < obs.size() && i < int'(x.n); i++)
                  check($sformatf("probe_seq[%0d]", i), int'(obs[i]), int'(x.seq[i]));
            end
            completions++;
            bcnt = 0;
            obs.delete();
         end
      end
   end

   task automatic issue(input int t, input int m);
      exp_t x;
      x = model(t, m);
      if (x.is_err) begin
         x.found  = last_found;
         x.probes = last_probes;
      end else begin
         last_found  = x.found;
         last_probes = x.probes;
      end
      q.push_back(x);
      tgt  = t;
      mode = m;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done();
      int c0;
      int k;
      c0 = completions;
      k = 0;
      while (completions == c0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      if (completions == c0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done/err within %0d cycles, expected one", k);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_probe"}, int'(probe), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_err"}, int'(err), 0);
      check({tag, "_found"}, int'(found), 0);
      check({tag, "_probes"}, int'(probes), 0);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst = 1'b0;

      issue(5, 0);  wait_done();
      issue(0, 0);  wait_done();
      issue(15, 0); wait_done();
      issue(9, 1);  wait_done();   // illegal g&l on first probe
      issue(4, 2);  wait_done();   // always g: error at probe 0

      // Abort during the second SAMPLE with reset.
      tgt = 5; mode = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("probe_before_abort", int'(probe), 3);
      check("busy_before_abort", int'(busy), 1);
      rst = 1'b1;
      last_found = '0;
      last_probes = '0;
      #2 check_reset_outputs("abort");
      @(posedge clk); #1 rst = 1'b0;
      issue(9, 0); wait_done();

      // start while busy must be ignored.
      issue(6, 0);
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();

      // start in the done cycle must be ignored.
      issue(10, 0);
      k = 0;
      while (!(done || err) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("done_seen_for_ignore", int'(done), 1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (30) @(posedge clk);
      #1 check("idle_after_ignored_start", int'(busy), 0);
      check("scoreboard_drained", q.size(), 0);

      // Randomised back-to-back searches.
      for (int i = 0; i < 24; i++) begin
         int t, m;
         t = int'($urandom_range(0, 15));
         m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         issue(t, m);
         wait_done();
      end

      repeat (4) @(posedge clk);
      check("final_scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
